// File: rtl/cpu.sv
// cpu: multi-cycle (fetch / optional indirect / execute) 32-bit core for a
// Xerox Sigma-style, word-addressed instruction subset. Bit 0 is the MSB
// throughout, matching the instruction-word field layout.
//
// Ports:
//   clock     in   system clock, all state changes on the rising edge
//   reset     in   asynchronous active-low reset
//   data_in   in   [0:31] memory read data (combinational function of address)
//   address   out  [15:31] word address to memory
//   write_en  out  memory write strobe, high only in the EXECUTE cycle of STW
//   data_out  out  [0:31] memory write data
module cpu #(
  parameter logic [15:31] RESET_PC = 17'h00000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [0:31]  data_in,
  output logic [15:31] address,
  output logic         write_en,
  output logic [0:31]  data_out
);

  localparam logic [0:1] ST_FETCH    = 2'd0;
  localparam logic [0:1] ST_INDIRECT = 2'd1;
  localparam logic [0:1] ST_EXECUTE  = 2'd2;
  localparam logic [0:1] ST_HALT     = 2'd3;

  localparam logic [0:6] OP_AI  = 7'h20;
  localparam logic [0:6] OP_CI  = 7'h21;
  localparam logic [0:6] OP_LI  = 7'h22;
  localparam logic [0:6] OP_AW  = 7'h30;
  localparam logic [0:6] OP_CW  = 7'h31;
  localparam logic [0:6] OP_LW  = 7'h32;
  localparam logic [0:6] OP_STW = 7'h35;
  localparam logic [0:6] OP_SW  = 7'h38;
  localparam logic [0:6] OP_EOR = 7'h48;
  localparam logic [0:6] OP_OR  = 7'h49;
  localparam logic [0:6] OP_AND = 7'h4B;
  localparam logic [0:6] OP_BCR = 7'h68;
  localparam logic [0:6] OP_BCS = 7'h69;
  localparam logic [0:6] OP_BAL = 7'h6A;

  // Immediate opcodes take their operand from bits 12-31 and ignore I and X.
  function automatic logic is_imm(input logic [0:6] op);
    is_imm = (op == OP_LI) || (op == OP_AI) || (op == OP_CI);
  endfunction

  function automatic logic is_impl(input logic [0:6] op);
    case (op)
      OP_AI, OP_CI, OP_LI, OP_AW, OP_CW, OP_LW, OP_STW, OP_SW,
      OP_EOR, OP_OR, OP_AND, OP_BCR, OP_BCS, OP_BAL: is_impl = 1'b1;
      default:                                        is_impl = 1'b0;
    endcase
  endfunction

  // {CC3, CC4}: positive / negative result.
  function automatic logic [0:1] sign_cc(input logic [0:31] v);
    sign_cc = {(v != 32'd0) && !v[0], v[0]};
  endfunction

  // {CC3, CC4}: signed greater / less than.
  function automatic logic [0:1] cmp_cc(input logic [0:31] a, input logic [0:31] b);
    cmp_cc = {$signed(a) > $signed(b), $signed(a) < $signed(b)};
  endfunction

  logic [0:1]   state_q, state_d;
  logic [0:31]  ir_q, ir_d;
  logic [15:31] pc_q, pc_d;
  logic [15:31] ptr_q, ptr_d;
  logic [0:3]   cc_q, cc_d;
  logic [0:31]  regs_q [0:15];
  logic         write_en_q, write_en_d;
  logic [0:31]  data_out_q, data_out_d;

  logic         reg_we_s;
  logic [0:3]   reg_idx_s;
  logic [0:31]  reg_wdata_s;

  logic         ind_s;
  logic [0:6]   op_s;
  logic [0:3]   rf_s;
  logic [0:2]   xf_s;
  logic [15:31] ref_s, base_s, index_s, ea_s;
  logic [0:31]  imm_s, rr_s, addb_s, res_s;
  logic         cin_s, ovf_s;
  logic [0:32]  sum_s;

  assign ind_s = ir_q[0];
  assign op_s  = ir_q[1:7];
  assign rf_s  = ir_q[8:11];
  assign xf_s  = ir_q[12:14];
  assign ref_s = ir_q[15:31];
  assign imm_s = {{12{ir_q[12]}}, ir_q[12:31]};
  assign rr_s  = regs_q[rf_s];

  // Indirection is resolved first (pointer latched in INDIRECT), then indexing.
  assign base_s  = (ind_s && !is_imm(op_s)) ? ptr_q : ref_s;
  assign index_s = (xf_s != 3'd0) ? regs_q[{1'b0, xf_s}][15:31] : 17'd0;
  assign ea_s    = base_s + index_s;

  // Shared adder: subtraction is R + ~M + 1, so CC1 is the carry out of that sum.
  assign cin_s  = (op_s == OP_SW);
  assign addb_s = (op_s == OP_SW) ? ~data_in : ((op_s == OP_AI) ? imm_s : data_in);
  assign sum_s  = {1'b0, rr_s} + {1'b0, addb_s} + {32'd0, cin_s};
  assign res_s  = sum_s[1:32];
  assign ovf_s  = (rr_s[0] == addb_s[0]) && (res_s[0] != rr_s[0]);

  assign write_en = write_en_q;
  assign data_out = data_out_q;

  // Memory address selection for the current cycle.
  always_comb begin
    address = pc_q;
    case (state_q)
      ST_FETCH:    address = pc_q;
      ST_INDIRECT: address = ref_s;
      ST_EXECUTE:  address = is_imm(op_s) ? pc_q : ea_s;
      default:     address = pc_q;
    endcase
  end

  // Next-state, datapath and condition-code logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ptr_d       = ptr_q;
    cc_d        = cc_q;
    reg_we_s    = 1'b0;
    reg_idx_s   = rf_s;
    reg_wdata_s = 32'd0;
    write_en_d  = 1'b0;
    data_out_d  = 32'd0;
    case (state_q)
      ST_FETCH: begin
        ir_d = data_in;
        pc_d = pc_q + 17'd1;
        if (!is_impl(data_in[1:7])) begin
          state_d = ST_HALT;
        end else if (data_in[0] && !is_imm(data_in[1:7])) begin
          state_d = ST_INDIRECT;
        end else begin
          state_d = ST_EXECUTE;
          // Store strobe is registered so it is high for exactly the EXECUTE cycle.
          if (data_in[1:7] == OP_STW) begin
            write_en_d = 1'b1;
            data_out_d = regs_q[data_in[8:11]];
          end else begin
            write_en_d = 1'b0;
          end
        end
      end
      ST_INDIRECT: begin
        ptr_d   = data_in[15:31];
        state_d = ST_EXECUTE;
        if (op_s == OP_STW) begin
          write_en_d = 1'b1;
          data_out_d = rr_s;
        end else begin
          write_en_d = 1'b0;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        case (op_s)
          OP_LI: begin
            reg_we_s    = 1'b1;
            reg_wdata_s = imm_s;
            cc_d[2:3]   = sign_cc(imm_s);
          end
          OP_LW: begin
            reg_we_s    = 1'b1;
            reg_wdata_s = data_in;
            cc_d[2:3]   = sign_cc(data_in);
          end
          OP_AI, OP_AW, OP_SW: begin
            reg_we_s    = 1'b1;
            reg_wdata_s = res_s;
            cc_d        = {sum_s[0], ovf_s, sign_cc(res_s)};
          end
          OP_CI:  cc_d[2:3] = cmp_cc(rr_s, imm_s);
          OP_CW:  cc_d[2:3] = cmp_cc(rr_s, data_in);
          OP_AND: begin
            reg_we_s    = 1'b1;
            reg_wdata_s = rr_s & data_in;
            cc_d[2:3]   = sign_cc(rr_s & data_in);
          end
          OP_OR: begin
            reg_we_s    = 1'b1;
            reg_wdata_s = rr_s | data_in;
            cc_d[2:3]   = sign_cc(rr_s | data_in);
          end
          OP_EOR: begin
            reg_we_s    = 1'b1;
            reg_wdata_s = rr_s ^ data_in;
            cc_d[2:3]   = sign_cc(rr_s ^ data_in);
          end
          OP_BCR: begin
            if ((cc_q & rf_s) == 4'd0) begin
              pc_d = ea_s;
            end else begin
              pc_d = pc_q;
            end
          end
          OP_BCS: begin
            if ((cc_q & rf_s) != 4'd0) begin
              pc_d = ea_s;
            end else begin
              pc_d = pc_q;
            end
          end
          OP_BAL: begin
            // pc_q already points past the BAL: that is the return address.
            reg_we_s    = 1'b1;
            reg_wdata_s = {15'd0, pc_q};
            pc_d        = ea_s;
          end
          OP_STW:  state_d = ST_FETCH;
          default: state_d = ST_HALT;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Architectural state; reset aborts any instruction and drops the store strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 32'd0;
      ptr_q      <= 17'd0;
      cc_q       <= 4'd0;
      write_en_q <= 1'b0;
      data_out_q <= 32'd0;
      for (int k = 0; k < 16; k++) begin
        regs_q[k] <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ptr_q      <= ptr_d;
      cc_q       <= cc_d;
      write_en_q <= write_en_d;
      data_out_q <= data_out_d;
      if (reg_we_s) begin
        regs_q[reg_idx_s] <= reg_wdata_s;
      end
    end
  end

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: drives the cpu with a word-addressed RAM model and checks it against
// an instruction-level reference model (one instruction per model step).
module tb_cpu;

  localparam logic [6:0] OP_AI  = 7'h20;
  localparam logic [6:0] OP_CI  = 7'h21;
  localparam logic [6:0] OP_LI  = 7'h22;
  localparam logic [6:0] OP_AW  = 7'h30;
  localparam logic [6:0] OP_CW  = 7'h31;
  localparam logic [6:0] OP_LW  = 7'h32;
  localparam logic [6:0] OP_STW = 7'h35;
  localparam logic [6:0] OP_SW  = 7'h38;
  localparam logic [6:0] OP_EOR = 7'h48;
  localparam logic [6:0] OP_OR  = 7'h49;
  localparam logic [6:0] OP_AND = 7'h4B;
  localparam logic [6:0] OP_BCR = 7'h68;
  localparam logic [6:0] OP_BCS = 7'h69;
  localparam logic [6:0] OP_BAL = 7'h6A;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rdata, wdata;
  logic [16:0] addr;
  logic        we;

  logic [31:0] ram  [0:131071];
  logic [31:0] mm   [0:131071];
  logic [31:0] regs [0:15];
  logic [3:0]  cc;
  logic [16:0] pc;
  int          visits [0:255];
  int          n_checks = 0;
  int          n_fail = 0;

  cpu #(.RESET_PC(17'h00000)) dut (
    .clock   (clock),
    .reset   (reset),
    .data_in (rdata),
    .address (addr),
    .write_en(we),
    .data_out(wdata)
  );

  always #5 clock = ~clock;

  assign rdata = ram[addr];

  always @(posedge clock) begin
    if (we) ram[addr] <= wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [16:0] a, input logic [31:0] d);
    ram[a] = d;
    mm[a]  = d;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 131072; i++) begin
      ram[i] = 32'd0;
      mm[i]  = 32'd0;
    end
  endtask

  function automatic logic [31:0] enc(input logic i, input logic [6:0] op, input logic [3:0] r,
                                      input logic [2:0] x, input logic [16:0] a);
    return {i, op, r, x, a};
  endfunction

  function automatic logic [31:0] enci(input logic [6:0] op, input logic [3:0] r, input logic [19:0] v);
    return {1'b0, op, r, v};
  endfunction

  function automatic logic implemented(input logic [6:0] op);
    return op inside {OP_AI, OP_CI, OP_LI, OP_AW, OP_CW, OP_LW, OP_STW, OP_SW,
                      OP_EOR, OP_OR, OP_AND, OP_BCR, OP_BCS, OP_BAL};
  endfunction

  function automatic logic immediate(input logic [6:0] op);
    return op inside {OP_AI, OP_CI, OP_LI};
  endfunction

  function automatic void set_nz(input logic [31:0] v);
    cc[1] = (v != 32'd0) && !v[31];
    cc[0] = v[31];
  endfunction

  // Reset, then execute up to max_instr instructions in lockstep with the model.
  task automatic run(input int max_instr);
    logic [31:0] w, v, a, b, opnd, res;
    logic [6:0]  op;
    logic [3:0]  r;
    logic [2:0]  x;
    logic [16:0] rf, ea;
    logic        ind, halted, carry;
    longint      sa, sb, s;
    int          diffs;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_addr", {15'd0, addr}, 32'd0);
    reset = 1'b1;
    pc = 17'd0;
    cc = 4'd0;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    for (int i = 0; i < 256; i++) visits[i] = 0;
    halted = 1'b0;
    for (int n = 0; n < max_instr && !halted; n++) begin
      check("fetch_addr", {15'd0, addr}, {15'd0, pc});
      check("fetch_we", {31'd0, we}, 32'd0);
      w = mm[pc];
      if (pc < 17'd256) visits[pc]++;
      pc  = pc + 17'd1;
      ind = w[31];
      op  = w[30:24];
      r   = w[23:20];
      x   = w[19:17];
      rf  = w[16:0];
      v   = {{12{w[19]}}, w[19:0]};
      if (!implemented(op)) begin
        halted = 1'b1;
        repeat (2) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
          check("halt_addr", {15'd0, addr}, {15'd0, pc});
          check("halt_we", {31'd0, we}, 32'd0);
          @(negedge clock);
        end
      end else begin
        ea = rf;
        if (ind && !immediate(op)) begin
          @(negedge clock);
          check("ind_addr", {15'd0, addr}, {15'd0, rf});
          check("ind_we", {31'd0, we}, 32'd0);
          ea = mm[rf][16:0];
        end
        if (x != 3'd0) ea = ea + regs[{1'b0, x}][16:0];
        @(negedge clock);
        opnd = mm[ea];
        a    = regs[r];
        if (op == OP_STW) begin
          check("exe_we", {31'd0, we}, 32'd1);
          check("exe_addr", {15'd0, addr}, {15'd0, ea});
          check("exe_data", wdata, a);
          mm[ea] = a;
        end else begin
          check("exe_we", {31'd0, we}, 32'd0);
        end
        case (op)
          OP_LI: begin regs[r] = v; set_nz(v); end
          OP_LW: begin regs[r] = opnd; set_nz(opnd); end
          OP_AI, OP_AW, OP_SW: begin
            b  = (op == OP_AI) ? v : opnd;
            sa = $signed(a);
            sb = $signed(b);
            if (op == OP_SW) begin
              s = sa - sb; res = a - b; carry = (a >= b);
            end else begin
              s = sa + sb; res = a + b; carry = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
            end
            cc[3] = carry;
            cc[2] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            regs[r] = res;
            set_nz(res);
          end
          OP_CI, OP_CW: begin
            b = (op == OP_CI) ? v : opnd;
            cc[1] = $signed(a) > $signed(b);
            cc[0] = $signed(a) < $signed(b);
          end
          OP_AND: begin regs[r] = a & opnd; set_nz(a & opnd); end
          OP_OR:  begin regs[r] = a | opnd; set_nz(a | opnd); end
          OP_EOR: begin regs[r] = a ^ opnd; set_nz(a ^ opnd); end
          OP_BCR: if ((cc & r) == 4'd0) pc = ea;
          OP_BCS: if ((cc & r) != 4'd0) pc = ea;
          OP_BAL: begin regs[r] = {15'd0, pc}; pc = ea; end
          default: ;
        endcase
        @(negedge clock);
      end
    end
    diffs = 0;
    for (int i = 0; i < 131072; i++) if (ram[i] !== mm[i]) diffs++;
    check("mem_image", diffs, 32'd0);
  endtask

  function automatic logic [6:0] pick_op(input int k);
    case (k % 14)
      0:  return OP_LI;
      1:  return OP_AI;
      2:  return OP_CI;
      3:  return OP_LW;
      4:  return OP_STW;
      5:  return OP_AW;
      6:  return OP_SW;
      7:  return OP_CW;
      8:  return OP_AND;
      9:  return OP_OR;
      10: return OP_EOR;
      11: return OP_BCR;
      12: return OP_BCS;
      default: return OP_BAL;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [6:0]  op;
    logic [2:0]  x;
    logic [16:0] a;
    logic        i;
    k  = $urandom_range(0, 60);
    op = (k == 60) ? 7'h7F : pick_op(k);
    i  = ($urandom_range(0, 3) == 0);
    x  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    if (op inside {OP_BCR, OP_BCS, OP_BAL}) a = 17'($urandom_range(0, 47));
    else a = 17'h100 + 17'($urandom_range(0, 63));
    if (immediate(op)) return enci(op, 4'($urandom_range(0, 15)), 20'($urandom()));
    return enc(i, op, 4'($urandom_range(0, 15)), x, a);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Store path, using the raw encodings.
    clear_mem();
    put(17'h0, 32'h22110001);
    put(17'h1, 32'h35100100);
    run(10);
    check("store_mem", ram[17'h100], 32'h00010001);

    // Memory add with carry: CC must be exactly 1000 to reach the marker store.
    clear_mem();
    put(17'h0, enci(OP_LI, 4'd2, 20'd5));
    put(17'h1, enc(1'b0, OP_AW, 4'd2, 3'd0, 17'h40));
    put(17'h2, enc(1'b0, OP_STW, 4'd2, 3'd0, 17'h41));
    put(17'h3, enc(1'b0, OP_BCR, 4'h7, 3'd0, 17'h5));
    put(17'h5, enc(1'b0, OP_BCS, 4'h8, 3'd0, 17'h7));
    put(17'h7, enci(OP_LI, 4'd7, 20'h07777));
    put(17'h8, enc(1'b0, OP_STW, 4'd7, 3'd0, 17'h42));
    put(17'h40, 32'hFFFFFFFB);
    put(17'h41, 32'h12345678);
    run(20);
    check("aw_result", ram[17'h41], 32'h0);
    check("aw_cc_marker", ram[17'h42], 32'h7777);

    // Countdown loop on CC3.
    clear_mem();
    put(17'h0, enci(OP_LI, 4'd3, 20'd3));
    put(17'h1, enci(OP_AI, 4'd3, 20'hFFFFF));
    put(17'h2, enc(1'b0, OP_BCS, 4'd2, 3'd0, 17'h1));
    put(17'h3, enc(1'b0, OP_STW, 4'd3, 3'd0, 17'h50));
    put(17'h50, 32'hFFFFFFFF);
    run(30);
    check("loop_count", visits[1], 32'd3);
    check("loop_result", ram[17'h50], 32'h0);

    // Indirect then indexed load.
    clear_mem();
    put(17'h60, 32'h00000070);
    put(17'h72, 32'hCAFEF00D);
    put(17'h0, enci(OP_LI, 4'd4, 20'd2));
    put(17'h1, enc(1'b1, OP_LW, 4'd5, 3'd4, 17'h60));
    put(17'h2, enc(1'b0, OP_STW, 4'd5, 3'd0, 17'h51));
    run(10);
    check("ind_idx_load", ram[17'h51], 32'hCAFEF00D);

    // BAL return address, then halt.
    clear_mem();
    for (int i = 0; i < 5; i++) put(17'(i), enci(OP_LI, 4'(i), 20'(i + 1)));
    put(17'h5, enc(1'b0, OP_BAL, 4'd6, 3'd0, 17'h20));
    put(17'h20, enc(1'b0, OP_STW, 4'd6, 3'd0, 17'h52));
    run(20);
    check("bal_link", ram[17'h52], 32'd6);
    check("bal_target", visits[32], 32'd1);

    // Reset during a store's EXECUTE cycle suppresses the write.
    clear_mem();
    put(17'h0, enc(1'b0, OP_STW, 4'd0, 3'd0, 17'h90));
    put(17'h90, 32'hDEADBEEF);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_we_before", {31'd0, we}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_we_after", {31'd0, we}, 32'd0);
    repeat (2) @(negedge clock);
    check("abort_mem", ram[17'h90], 32'hDEADBEEF);

    // Random programs, ending with a dump of every register.
    for (int t = 0; t < 6; t++) begin
      clear_mem();
      for (int a = 0; a < 48; a++) put(17'(a), rand_instr());
      for (int i = 0; i < 16; i++) put(17'(48 + i), enc(1'b0, OP_STW, 4'(i), 3'd0, 17'h1C0 + 17'(i)));
      for (int a = 256; a < 320; a++) put(17'(a), $urandom());
      run(300);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
